// File: rtl/game_pkg.sv
// Shared definitions for the binary-guess round sequencer.
//  game_state_e : FSM state encoding (IDLE=0 .. OVER=6), also driven on state_o
//  LFSR_TAPS    : feedback tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//  SCORE_MAX    : score saturation value
//  LIVES_INIT   : lives at game start (used with GAME_CTRL_LIVES_EN)
//  lfsr_next()  : one Fibonacci step, shift left with feedback into bit 0
package game_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      PLAY   = 3'd3,
      HIT    = 3'd4,
      MISS   = 3'd5,
      OVER   = 3'd6
   } game_state_e;

   localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;
   localparam logic [7:0] SCORE_MAX  = 8'd255;
   localparam logic [1:0] LIVES_INIT = 2'd3;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the round sequencer and the front end / display.
//  start      : single-cycle start pulse (front end -> ctrl)
//  is_equal   : registered comparator result (front end -> ctrl)
//  number     : target value (ctrl -> comparator/display)
//  time_left  : remaining ticks in round
//  score      : rounds won this game
//  state_o    : FSM state encoding
//  hit, miss  : single-cycle round outcome pulses
//  game_over  : high while in OVER
//  lives      : remaining lives, only when GAME_CTRL_LIVES_EN is defined
// Modports: master = controller side, slave = front end side.
interface game_round_ctrl_if;

   logic       start;
   logic       is_equal;
   logic [7:0] number;
   logic [7:0] time_left;
   logic [7:0] score;
   logic [2:0] state_o;
   logic       hit;
   logic       miss;
   logic       game_over;
`ifdef GAME_CTRL_LIVES_EN
   logic [1:0] lives;

   modport master (
      input  start, is_equal,
      output number, time_left, score, state_o, hit, miss, game_over, lives
   );
   modport slave (
      output start, is_equal,
      input  number, time_left, score, state_o, hit, miss, game_over, lives
   );
`else
   modport master (
      input  start, is_equal,
      output number, time_left, score, state_o, hit, miss, game_over
   );
   modport slave (
      output start, is_equal,
      input  number, time_left, score, state_o, hit, miss, game_over
   );
`endif

endinterface

// File: rtl/game_round_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advances by one step when step is high.
//  clk, rst : clock and asynchronous active-high reset (loads SEED)
//  step     : advance enable
//  q        : current LFSR value (never 0 given a nonzero SEED)
module lfsr8
   import game_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [7:0] q
);

   logic [7:0] q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= SEED;
      end else if (step) begin
         q_q <= lfsr_next(q_q);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the binary-guess game: loads an LFSR target, runs a per-round countdown
// and scores from the comparator's registered is_equal.
//  clk, rst : clock and asynchronous active-high reset
//  bus      : game_round_ctrl_if.master (start/is_equal in; number, time_left, score,
//             state_o, hit, miss, game_over [, lives] out; all outputs registered)
// Optional feature macro: GAME_CTRL_LIVES_EN adds a lives counter; MISS returns to LOAD
// until the last life is spent.
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned ROUND_SECS = 10,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input logic         clk,
   input logic         rst,
   game_round_ctrl_if.master bus
);

   localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

   game_state_e      state_q, state_d;
   logic [7:0]       number_q, number_d;
   logic [7:0]       time_q, time_d;
   logic [7:0]       score_q, score_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic             hit_q, miss_q, over_q;
   logic [7:0]       lfsr_q;
   logic             wrap;
`ifdef GAME_CTRL_LIVES_EN
   logic [1:0]       lives_q, lives_d;
`endif

   // LFSR advances only in LOAD, in the same cycle its value is copied into number.
   lfsr8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (state_q == LOAD),
      .q    (lfsr_q)
   );

   assign wrap = (tick_q == TickLast);

   always_comb begin
      state_d  = state_q;
      number_d = number_q;
      time_d   = time_q;
      score_d  = score_q;
      tick_d   = tick_q;
`ifdef GAME_CTRL_LIVES_EN
      lives_d  = lives_q;
`endif
      case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d = LOAD;
               score_d = 8'd0;
`ifdef GAME_CTRL_LIVES_EN
               lives_d = LIVES_INIT;
`endif
            end
         end
         LOAD: begin
            number_d = lfsr_q;
            time_d   = 8'(ROUND_SECS);
            tick_d   = '0;
            state_d  = SETTLE;
         end
         // is_equal still reflects the previous number here.
         SETTLE: state_d = PLAY;
         PLAY: begin
            tick_d = wrap ? '0 : tick_q + 1'b1;
            // A match beats a simultaneous final wrap; time_left is left untouched.
            if (bus.is_equal) begin
               state_d = HIT;
               score_d = (score_q == SCORE_MAX) ? score_q : score_q + 8'd1;
            end else if (wrap) begin
               time_d = time_q - 8'd1;
               if (time_q == 8'd1) begin
                  state_d = MISS;
               end
            end
         end
         HIT: state_d = LOAD;
         MISS: begin
`ifdef GAME_CTRL_LIVES_EN
            lives_d = lives_q - 2'd1;
            state_d = (lives_q > 2'd1) ? LOAD : OVER;
`else
            state_d = OVER;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         number_q <= 8'd0;
         time_q   <= 8'd0;
         score_q  <= 8'd0;
         tick_q   <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         number_q <= number_d;
         time_q   <= time_d;
         score_q  <= score_d;
         tick_q   <= tick_d;
         // Flag registers track the state being entered so they align with state_o.
         hit_q    <= (state_d == HIT);
         miss_q   <= (state_d == MISS);
         over_q   <= (state_d == OVER);
      end
   end

`ifdef GAME_CTRL_LIVES_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lives_q <= LIVES_INIT;
      end else begin
         lives_q <= lives_d;
      end
   end

   assign bus.lives = lives_q;
`endif

   assign bus.number    = number_q;
   assign bus.time_left = time_q;
   assign bus.score     = score_q;
   assign bus.state_o   = state_q;
   assign bus.hit       = hit_q;
   assign bus.miss      = miss_q;
   assign bus.game_over = over_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with TICK_DIV=4, ROUND_SECS=3 and a 1-cycle comparator.
module tb_game_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic [7:0] model_lfsr;
   logic [7:0] last_num;
   int         errors = 0;
   int         checks = 0;

   game_round_ctrl_if bus ();

   game_round_ctrl #(
      .TICK_DIV   (4),
      .ROUND_SECS (3),
      .LFSR_SEED  (8'hA5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Comparator model: registered equality, one cycle behind number.
   always @(posedge clk) bus.is_equal <= (sw == bus.number);

   function automatic logic [7:0] step_lfsr(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.start = 1'b0; sw = 8'h00; model_lfsr = 8'hA5;
      cyc(2);
      checks++; if (bus.state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state_o); end
      checks++; if (bus.number !== 8'h00) begin errors++; $display("FAIL reset_number: got %h want 00", bus.number); end
      checks++; if (bus.score !== 8'h00 || bus.time_left !== 8'h00) begin errors++; $display("FAIL reset_score_time: got %h/%h want 00/00", bus.score, bus.time_left); end
      checks++; if ({bus.hit, bus.miss, bus.game_over} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {bus.hit, bus.miss, bus.game_over}); end
      rst = 1'b0;
      cyc(1);
   endtask

   // Start, first round load, and a win on the first PLAY cycle.
   task automatic test_first_round;
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      checks++; if (bus.state_o !== 3'd1) begin errors++; $display("FAIL load_state: got %0d want 1", bus.state_o); end
      cyc(1);
      checks++; if (bus.number !== 8'hA5) begin errors++; $display("FAIL first_number: got %h want a5", bus.number); end
      checks++; if (bus.time_left !== 8'd3) begin errors++; $display("FAIL first_time: got %0d want 3", bus.time_left); end
      checks++; if (bus.state_o !== 3'd2 || bus.hit !== 1'b0) begin errors++; $display("FAIL settle: got state %0d hit %b want 2/0", bus.state_o, bus.hit); end
      sw = 8'hA5;
      model_lfsr = step_lfsr(model_lfsr);
      cyc(1);
      checks++; if (bus.state_o !== 3'd3 || bus.hit !== 1'b0) begin errors++; $display("FAIL play_entry: got state %0d hit %b want 3/0", bus.state_o, bus.hit); end
      cyc(1);
      checks++; if (bus.hit !== 1'b1 || bus.state_o !== 3'd4) begin errors++; $display("FAIL first_hit: got hit %b state %0d want 1/4", bus.hit, bus.state_o); end
      checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL first_score: got %0d want 1", bus.score); end
      cyc(1);
      checks++; if (bus.hit !== 1'b0 || bus.state_o !== 3'd1) begin errors++; $display("FAIL hit_pulse_end: got hit %b state %0d want 0/1", bus.hit, bus.state_o); end
   endtask

   // Countdown to timeout; starts at a LOAD negedge.
   task automatic test_timeout;
      int rounds;
`ifdef GAME_CTRL_LIVES_EN
      rounds = 3;
`else
      rounds = 1;
`endif
      for (int r = 0; r < rounds; r++) begin
         cyc(1);
         if (r == 0) begin
            checks++; if (bus.number !== 8'h4A) begin errors++; $display("FAIL second_number: got %h want 4a", bus.number); end
         end
         checks++; if (bus.number !== model_lfsr) begin errors++; $display("FAIL timeout_number: got %h want %h", bus.number, model_lfsr); end
         last_num = model_lfsr;
         model_lfsr = step_lfsr(model_lfsr);
         sw = 8'h00;
         cyc(1);
         checks++; if (bus.time_left !== 8'd3) begin errors++; $display("FAIL tl_3: got %0d want 3", bus.time_left); end
         cyc(4);
         checks++; if (bus.time_left !== 8'd2) begin errors++; $display("FAIL tl_2: got %0d want 2", bus.time_left); end
         cyc(4);
         checks++; if (bus.time_left !== 8'd1) begin errors++; $display("FAIL tl_1: got %0d want 1", bus.time_left); end
         cyc(4);
         checks++; if (bus.state_o !== 3'd5 || bus.miss !== 1'b1 || bus.time_left !== 8'd0) begin errors++; $display("FAIL miss: got state %0d miss %b tl %0d want 5/1/0", bus.state_o, bus.miss, bus.time_left); end
         cyc(1);
         checks++; if (bus.miss !== 1'b0 || bus.hit !== 1'b0) begin errors++; $display("FAIL miss_pulse_end: got miss %b hit %b want 0/0", bus.miss, bus.hit); end
`ifdef GAME_CTRL_LIVES_EN
         checks++; if (bus.lives !== 2'(2 - r)) begin errors++; $display("FAIL lives: got %0d want %0d", bus.lives, 2 - r); end
         checks++; if (bus.state_o !== ((r < 2) ? 3'd1 : 3'd6)) begin errors++; $display("FAIL lives_state: got %0d want %0d", bus.state_o, (r < 2) ? 1 : 6); end
`endif
      end
      checks++; if (bus.state_o !== 3'd6 || bus.game_over !== 1'b1) begin errors++; $display("FAIL over: got state %0d go %b want 6/1", bus.state_o, bus.game_over); end
      checks++; if (bus.number !== last_num) begin errors++; $display("FAIL over_number_held: got %h want %h", bus.number, last_num); end
      checks++; if (bus.score !== 8'd1) begin errors++; $display("FAIL over_score_held: got %0d want 1", bus.score); end
   endtask

   // Restart from OVER, then 256 consecutive wins; score must saturate at 255.
   task automatic test_score_saturate;
      int bad_num;
      bad_num = 0;
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      checks++; if (bus.state_o !== 3'd1 || bus.score !== 8'd0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL restart: got state %0d score %0d go %b want 1/0/0", bus.state_o, bus.score, bus.game_over); end
`ifdef GAME_CTRL_LIVES_EN
      checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL restart_lives: got %0d want 3", bus.lives); end
`endif
      for (int k = 1; k <= 256; k++) begin
         cyc(1);
         if (bus.number !== model_lfsr) bad_num++;
         sw = model_lfsr;
         model_lfsr = step_lfsr(model_lfsr);
         cyc(2);
         if (k == 255 || k == 256) begin
            checks++; if (bus.hit !== 1'b1 || bus.score !== 8'd255) begin errors++; $display("FAIL saturate_%0d: got hit %b score %0d want 1/255", k, bus.hit, bus.score); end
         end
         cyc(1);
      end
      checks++; if (bad_num !== 0) begin errors++; $display("FAIL lfsr_sequence: got %0d wrong targets want 0", bad_num); end
   endtask

   // Match lands on the cycle of the final tick wrap; start during PLAY is ignored.
   task automatic test_final_tick_hit;
      cyc(1);
      last_num = model_lfsr;
      model_lfsr = step_lfsr(model_lfsr);
      sw = 8'h00;
      cyc(1);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      checks++; if (bus.state_o !== 3'd3 || bus.score !== 8'd255) begin errors++; $display("FAIL start_ignored: got state %0d score %0d want 3/255", bus.state_o, bus.score); end
      cyc(9);
      sw = last_num;
      cyc(1);
      checks++; if (bus.state_o !== 3'd3 || bus.time_left !== 8'd1) begin errors++; $display("FAIL pre_final: got state %0d tl %0d want 3/1", bus.state_o, bus.time_left); end
      cyc(1);
      checks++; if (bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.time_left !== 8'd1) begin errors++; $display("FAIL final_tick_hit: got hit %b miss %b tl %0d want 1/0/1", bus.hit, bus.miss, bus.time_left); end
      cyc(1);
      checks++; if (bus.miss !== 1'b0 || bus.state_o !== 3'd1) begin errors++; $display("FAIL final_tick_after: got miss %b state %0d want 0/1", bus.miss, bus.state_o); end
   endtask

   // Asynchronous reset in the middle of PLAY, then a fresh game restarts the LFSR.
   task automatic test_reset_mid_play;
      sw = 8'h00;
      cyc(2);
      checks++; if (bus.state_o !== 3'd3) begin errors++; $display("FAIL pre_reset_state: got %0d want 3", bus.state_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.state_o !== 3'd0 || bus.number !== 8'h00) begin errors++; $display("FAIL async_reset_state: got state %0d num %h want 0/00", bus.state_o, bus.number); end
      checks++; if (bus.time_left !== 8'd0 || bus.score !== 8'd0) begin errors++; $display("FAIL async_reset_counts: got tl %0d score %0d want 0/0", bus.time_left, bus.score); end
      checks++; if ({bus.hit, bus.miss, bus.game_over} !== 3'b000) begin errors++; $display("FAIL async_reset_flags: got %b want 000", {bus.hit, bus.miss, bus.game_over}); end
`ifdef GAME_CTRL_LIVES_EN
      checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL async_reset_lives: got %0d want 3", bus.lives); end
`endif
      cyc(1);
      rst = 1'b0;
      cyc(1);
      checks++; if (bus.state_o !== 3'd0 || bus.hit !== 1'b0 || bus.miss !== 1'b0) begin errors++; $display("FAIL post_reset: got state %0d hit %b miss %b want 0/0/0", bus.state_o, bus.hit, bus.miss); end
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(1);
      checks++; if (bus.number !== 8'hA5) begin errors++; $display("FAIL reseed: got %h want a5", bus.number); end
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_timeout();
      test_score_saturate();
      test_final_tick_hit();
      test_reset_mid_play();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
